// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: accepts operand pairs, drives the subtractive GCD core and returns results.
// Define GCD_TIMEOUT_EN to add a RUN-state watchdog of TIMEOUT_CYCLES cycles.
module gcd_job_sequencer #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 70000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_zero,
  output logic             out_timeout,
  output logic             gcd_clr,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD_A,
    LOAD_B,
    RUN,
    RESP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

`ifdef GCD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] run_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  assign in_ready = (state == IDLE) && !rst;

  // Zero operands skip the core entirely: subtractive GCD would never terminate on them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      out_valid   <= 1'b0;
      out_gcd     <= '0;
      out_zero    <= 1'b0;
      out_timeout <= 1'b0;
      gcd_clr     <= 1'b0;
      gcd_start   <= 1'b0;
      gcd_data    <= '0;
`ifdef GCD_TIMEOUT_EN
      run_cnt     <= '0;
`endif
    end else begin
      gcd_clr   <= 1'b0;
      gcd_start <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a        <= in_a;
            op_b        <= in_b;
            out_timeout <= 1'b0;
            if (in_a == '0 || in_b == '0) begin
              out_gcd   <= in_a | in_b;
              out_zero  <= (in_a == '0) && (in_b == '0);
              out_valid <= 1'b1;
              state     <= RESP;
            end else begin
              out_zero <= 1'b0;
              gcd_clr  <= 1'b1;
              state    <= CLR;
            end
          end
        end
        CLR: begin
          gcd_start <= 1'b1;
          gcd_data  <= op_a;
          state     <= LOAD_A;
        end
        LOAD_A: begin
          gcd_data <= op_b;
          state    <= LOAD_B;
        end
        LOAD_B: begin
`ifdef GCD_TIMEOUT_EN
          run_cnt <= '0;
`endif
          state <= RUN;
        end
        RUN: begin
          // A done in the final watchdog cycle still delivers the real result.
          if (gcd_done) begin
            out_gcd   <= gcd_result;
            out_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef GCD_TIMEOUT_EN
          else if (run_cnt == RUN_LAST) begin
            out_gcd     <= '0;
            out_zero    <= 1'b0;
            out_timeout <= 1'b1;
            out_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
